atomic_counter_bank: RTL and testbench

- Bank of NUM_CH independent event counters, each COUNTLEN bits wide, read over a narrower DATABUS-bit bus.
- Successor to the single-channel 64/32 atomic counter, generalised in:
  - channel count
  - counter width and bus width, giving any number of beats per read
  - wrap or saturate mode
  - clear-on-read
  - a busy indication
- Sits beside the event sources. A software-facing register slave pulses req_i/atomic_i and collects words on count_o qualified by ack_o.

---
 rtl/atomic_counter_bank.sv | 121 ++++++++++++
 tb/tb_atomic_counter_bank.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atomic_counter_bank.sv
// rtl/atomic_counter_bank.sv - bank of event counters read as atomic multi-beat snapshots
// An atomic start freezes one counter into a shadow register that later beats drain one bus word at a time.
module atomic_counter_bank #(
  parameter int NUM_CH   = 4,
  parameter int COUNTLEN = 64,
  parameter int DATABUS  = 32,
  parameter int SATURATE = 0,
  localparam int BEATS   = COUNTLEN / DATABUS,
  localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  trig_i,
  input  logic               req_i,
  input  logic               atomic_i,
  input  logic [CHW-1:0]     ch_sel_i,
  input  logic               clr_i,
  output logic               ack_o,
  output logic [DATABUS-1:0] count_o,
  output logic               busy_o
);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {S_IDLE, S_ATOMIC} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [COUNTLEN-1:0] shadow_q, shadow_d;
  logic [COUNTLEN-1:0] cnt_q [NUM_CH];
  logic [COUNTLEN-1:0] cnt_d [NUM_CH];
  logic                ack_q, ack_d;
  logic [DATABUS-1:0]  count_q, count_d;

  logic [COUNTLEN-1:0] sel_val;
  logic [DATABUS-1:0]  beat_word;
  logic                start;

  assign start = req_i & atomic_i;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_val = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel_i == CHW'(n)) sel_val = cnt_q[n];
    end
  end

  always_comb begin
    beat_word = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BW'(b)) beat_word = shadow_q[b*DATABUS +: DATABUS];
    end
  end

  // A clear in the snapshot cycle keeps that cycle's own event.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      cnt_d[n] = cnt_q[n];
      if (start && clr_i && (ch_sel_i == CHW'(n))) begin
        cnt_d[n] = COUNTLEN'(trig_i[n]);
      end else if (trig_i[n]) begin
        if (&cnt_q[n]) cnt_d[n] = (SATURATE != 0) ? cnt_q[n] : '0;
        else           cnt_d[n] = cnt_q[n] + COUNTLEN'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    ack_d    = 1'b0;
    count_d  = count_q;
    if (req_i) begin
      ack_d = 1'b1;
      if (atomic_i) begin
        shadow_d = sel_val;
        count_d  = sel_val[DATABUS-1:0];
        if (BEATS > 1) begin
          state_d = S_ATOMIC;
          beat_d  = BW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end else if (state_q == S_ATOMIC) begin
        count_d = beat_word;
        if (beat_q == BW'(BEATS - 1)) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end else begin
        count_d = sel_val[DATABUS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      shadow_q <= '0;
      ack_q    <= 1'b0;
      count_q  <= '0;
      for (int n = 0; n < NUM_CH; n++) cnt_q[n] <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      count_q  <= count_d;
      for (int n = 0; n < NUM_CH; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign ack_o   = ack_q;
  assign count_o = count_q;
  assign busy_o  = (state_q == S_ATOMIC);

endmodule

// File: tb/tb_atomic_counter_bank.sv
// tb/tb_atomic_counter_bank.sv - five parameterisations driven in lockstep against one behavioural model
module tb_atomic_counter_bank;
  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] trig;
  logic       req, atomic, clr;
  logic [1:0] sel;
  logic       rn_want;

  always #5 clk = ~clk;

  int    p_nch  [NI] = '{4, 4, 3, 4, 4};
  int    p_clen [NI] = '{64, 8, 96, 16, 8};
  int    p_dbus [NI] = '{32, 8, 32, 8, 8};
  int    p_sat  [NI] = '{0, 1, 0, 0, 0};
  string nm_i   [NI] = '{"A", "B", "C", "D", "E"};

  logic        ack_a, ack_b, ack_c, ack_d, ack_e;
  logic        busy_a, busy_b, busy_c, busy_d, busy_e;
  logic [31:0] cnt_a, cnt_c;
  logic [7:0]  cnt_b, cnt_d, cnt_e;

  atomic_counter_bank #(.NUM_CH(4), .COUNTLEN(64), .DATABUS(32), .SATURATE(0)) u_a (
    .clk(clk), .reset(reset), .trig_i(trig), .req_i(req), .atomic_i(atomic),
    .ch_sel_i(sel), .clr_i(clr), .ack_o(ack_a), .count_o(cnt_a), .busy_o(busy_a));
  atomic_counter_bank #(.NUM_CH(4), .COUNTLEN(8), .DATABUS(8), .SATURATE(1)) u_b (
    .clk(clk), .reset(reset), .trig_i(trig), .req_i(req), .atomic_i(atomic),
    .ch_sel_i(sel), .clr_i(clr), .ack_o(ack_b), .count_o(cnt_b), .busy_o(busy_b));
  atomic_counter_bank #(.NUM_CH(3), .COUNTLEN(96), .DATABUS(32), .SATURATE(0)) u_c (
    .clk(clk), .reset(reset), .trig_i(trig[2:0]), .req_i(req), .atomic_i(atomic),
    .ch_sel_i(sel), .clr_i(clr), .ack_o(ack_c), .count_o(cnt_c), .busy_o(busy_c));
  atomic_counter_bank #(.NUM_CH(4), .COUNTLEN(16), .DATABUS(8), .SATURATE(0)) u_d (
    .clk(clk), .reset(reset), .trig_i(trig), .req_i(req), .atomic_i(atomic),
    .ch_sel_i(sel), .clr_i(clr), .ack_o(ack_d), .count_o(cnt_d), .busy_o(busy_d));
  atomic_counter_bank #(.NUM_CH(4), .COUNTLEN(8), .DATABUS(8), .SATURATE(0)) u_e (
    .clk(clk), .reset(reset), .trig_i(trig), .req_i(req), .atomic_i(atomic),
    .ch_sel_i(sel), .clr_i(clr), .ack_o(ack_e), .count_o(cnt_e), .busy_o(busy_e));

  logic        d_ack  [NI];
  logic        d_busy [NI];
  logic [31:0] d_cnt  [NI];

  assign d_ack[0] = ack_a;  assign d_busy[0] = busy_a;  assign d_cnt[0] = cnt_a;
  assign d_ack[1] = ack_b;  assign d_busy[1] = busy_b;  assign d_cnt[1] = {24'd0, cnt_b};
  assign d_ack[2] = ack_c;  assign d_busy[2] = busy_c;  assign d_cnt[2] = cnt_c;
  assign d_ack[3] = ack_d;  assign d_busy[3] = busy_d;  assign d_cnt[3] = {24'd0, cnt_d};
  assign d_ack[4] = ack_e;  assign d_busy[4] = busy_e;  assign d_cnt[4] = {24'd0, cnt_e};

  // Model state: what each DUT's outputs must show after the coming clock edge.
  logic [127:0] m_cnt    [NI][4];
  logic [127:0] m_shadow [NI];
  int           m_beat   [NI];
  bit           m_busy   [NI];
  bit           m_ack    [NI];
  logic [31:0]  m_count  [NI];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic void check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%s t=%0t got=%h want=%h", nm, nm_i[i], $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 4; c++) m_cnt[i][c] = '0;
      m_shadow[i] = '0;
      m_beat[i]   = 0;
      m_busy[i]   = 1'b0;
      m_ack[i]    = 1'b0;
      m_count[i]  = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      logic [127:0] cmax;
      logic [127:0] dmask;
      logic [127:0] live;
      int           beats;
      bit           hit;
      bit           do_clr;
      cmax   = (128'd1 << p_clen[i]) - 128'd1;
      dmask  = (128'd1 << p_dbus[i]) - 128'd1;
      beats  = p_clen[i] / p_dbus[i];
      hit    = int'(sel) < p_nch[i];
      live   = hit ? m_cnt[i][sel] : 128'd0;
      do_clr = 1'b0;
      m_ack[i] = 1'b0;
      if (req) begin
        m_ack[i] = 1'b1;
        if (atomic) begin
          m_shadow[i] = live;
          m_count[i]  = 32'(live & dmask);
          m_busy[i]   = beats > 1;
          m_beat[i]   = 1;
          do_clr      = clr && hit;
        end else if (m_busy[i]) begin
          m_count[i] = 32'((m_shadow[i] >> (m_beat[i] * p_dbus[i])) & dmask);
          if (m_beat[i] == beats - 1) m_busy[i] = 1'b0;
          else m_beat[i]++;
        end else begin
          m_count[i] = 32'(live & dmask);
        end
      end
      for (int c = 0; c < p_nch[i]; c++) begin
        if (do_clr && c == int'(sel)) m_cnt[i][c] = {127'd0, trig[c]};
        else if (trig[c]) begin
          if (m_cnt[i][c] == cmax) m_cnt[i][c] = (p_sat[i] != 0) ? cmax : 128'd0;
          else m_cnt[i][c] = m_cnt[i][c] + 128'd1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("ack",   i, 32'(d_ack[i]),  32'(m_ack[i]));
        check("count", i, d_cnt[i],       m_count[i]);
        check("busy",  i, 32'(d_busy[i]), 32'(m_busy[i]));
      end
    end
  end

  // After cyc returns, DUT outputs reflect the previous call's inputs.
  task automatic cyc(input logic [3:0] t, input logic r, input logic a, input logic [1:0] s, input logic c);
    @(negedge clk);
    #1;
    reset  = rn_want;
    trig   = t;
    req    = r;
    atomic = a;
    sel    = s;
    clr    = c;
    if (!reset) model_reset();
    else model_step();
  endtask

  initial begin
    reset = 1'b1; rn_want = 1'b0;
    trig = '0; req = 1'b0; atomic = 1'b0; sel = '0; clr = 1'b0;
    #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) cyc(4'b0000, 0, 0, 2'd0, 0);
    rn_want = 1'b1;

    repeat (10) cyc(4'b0001, 0, 0, 2'd0, 0);
    cyc(4'b0000, 1, 1, 2'd0, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    check("lit_ch0_beat0", 0, d_cnt[0], 32'h0000000A);
    check("lit_busy_mid", 0, 32'(d_busy[0]), 32'd1);
    cyc(4'b0000, 0, 0, 2'd0, 0);
    check("lit_ch0_beat1", 0, d_cnt[0], 32'h00000000);
    check("lit_busy_end", 0, 32'(d_busy[0]), 32'd0);
    cyc(4'b0000, 1, 1, 2'd1, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    check("lit_ch1_beat0", 0, d_cnt[0], 32'h00000000);
    cyc(4'b0000, 0, 0, 2'd0, 0);

    repeat (255) cyc(4'b0100, 0, 0, 2'd0, 0);
    cyc(4'b0000, 1, 1, 2'd2, 0);
    cyc(4'b0100, 0, 0, 2'd0, 0);
    check("lit_carry_b0", 3, d_cnt[3], 32'h000000FF);
    repeat (4) cyc(4'b0100, 0, 0, 2'd0, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    cyc(4'b0000, 0, 0, 2'd0, 0);
    check("lit_carry_b1", 3, d_cnt[3], 32'h00000000);
    cyc(4'b0000, 1, 1, 2'd2, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    check("lit_carry2_b0", 3, d_cnt[3], 32'h00000004);
    cyc(4'b0000, 0, 0, 2'd0, 0);
    check("lit_carry2_b1", 3, d_cnt[3], 32'h00000001);

    repeat (7) cyc(4'b0010, 0, 0, 2'd0, 0);
    cyc(4'b0010, 1, 1, 2'd1, 1);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    check("lit_clr_b0", 0, d_cnt[0], 32'h00000007);
    cyc(4'b0000, 0, 0, 2'd0, 0);
    cyc(4'b0000, 1, 1, 2'd1, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    check("lit_after_clr", 0, d_cnt[0], 32'h00000001);
    cyc(4'b0000, 0, 0, 2'd0, 0);

    repeat (300) cyc(4'b1000, 0, 0, 2'd0, 0);
    cyc(4'b0000, 1, 1, 2'd3, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    check("lit_sat", 1, d_cnt[1], 32'h000000FF);
    check("lit_wrap", 4, d_cnt[4], 32'h0000002C);
    check("lit_300", 0, d_cnt[0], 32'h0000012C);
    cyc(4'b0000, 0, 0, 2'd0, 0);

    cyc(4'b0000, 1, 1, 2'd0, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    cyc(4'b0000, 1, 1, 2'd2, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    check("lit_abort_b0", 2, d_cnt[2], 32'h00000104);
    check("lit_abort_busy", 2, 32'(d_busy[2]), 32'd1);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    check("lit_abort_b1", 2, d_cnt[2], 32'h00000000);
    cyc(4'b0000, 0, 0, 2'd0, 0);
    check("lit_abort_b2", 2, d_cnt[2], 32'h00000000);
    check("lit_abort_idle", 2, 32'(d_busy[2]), 32'd0);
    cyc(4'b0000, 1, 1, 2'd3, 1);
    cyc(4'b0000, 0, 0, 2'd0, 0);
    check("lit_oor_ack", 2, 32'(d_ack[2]), 32'd1);
    check("lit_oor_val", 2, d_cnt[2], 32'h00000000);
    check("lit_oor_busy", 2, 32'(d_busy[2]), 32'd1);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    cyc(4'b0000, 0, 0, 2'd0, 0);

    cyc(4'b0001, 1, 1, 2'd0, 0);
    cyc(4'b0000, 0, 0, 2'd0, 0);
    check("lit_pre_rst_busy", 0, 32'(d_busy[0]), 32'd1);
    #2;
    rn_want = 1'b0;
    reset   = 1'b0;
    model_reset();
    #1;
    check("lit_rst_ack", 0, 32'(d_ack[0]), 32'd0);
    check("lit_rst_cnt", 0, d_cnt[0], 32'd0);
    check("lit_rst_busy", 0, 32'(d_busy[0]), 32'd0);
    repeat (2) cyc(4'b0000, 0, 0, 2'd0, 0);
    rn_want = 1'b1;
    repeat (3) cyc(4'b0001, 0, 0, 2'd0, 0);
    cyc(4'b0000, 1, 0, 2'd0, 0);
    cyc(4'b0000, 1, 0, 2'd1, 0);
    check("lit_rst_live", 0, d_cnt[0], 32'h00000003);
    cyc(4'b0000, 0, 0, 2'd0, 0);
    check("lit_rst_ch1", 0, d_cnt[0], 32'h00000000);

    for (int k = 0; k < 4000; k++) begin
      rn_want = ($urandom_range(0, 399) != 0);
      cyc(4'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
          2'($urandom), $urandom_range(0, 9) < 3);
    end
    rn_want = 1'b1;
    repeat (2) cyc(4'b0000, 0, 0, 2'd0, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
